scrod_ack_conditioner: RTL and testbench

Front-end stage directly upstream of the trigger decision logic (TRIG). Takes the 12 raw, asynchronous per-SCROD ACK lines from the backplane and synchronises them into CLK_80MHZ. Stretches each accepted rising edge into a fixed-length coincidence window so that the downstream MIN_SCRODS_REQUIRED vote sees overlapping ACKs. Detects and quarantines stuck-high lines, and keeps a saturating count of accepted ACK edges for monitoring.

---
 rtl/caji_trg_pkg.sv | 33 +++
 rtl/scrod_ack_chan.sv | 94 +++++++++
 rtl/scrod_ack_conditioner.sv | 76 +++++++
 tb/tb_scrod_ack_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/caji_trg_pkg.sv
// Shared trigger-path constants, the ACK bus type and a saturating adder
// for the edge counter.
// Contents:
//   NUM_SCRODS / ACK_W        number of SCROD ACK channels and ACK bus width
//   SYNC_STAGES               synchroniser depth
//   STRETCH_W / STUCK_W       widths of the window and high-time counters
//   EDGE_CNT_W                width of the accepted-edge counter
//   DEF_STRETCH_LEN / DEF_STUCK_LIMIT  power-on defaults for software
package caji_trg_pkg;

  localparam int unsigned NUM_SCRODS  = 12;
  localparam int unsigned ACK_W       = NUM_SCRODS;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned STRETCH_W   = 4;
  localparam int unsigned STUCK_W     = 16;
  localparam int unsigned EDGE_CNT_W  = 32;

  localparam logic [STRETCH_W-1:0] DEF_STRETCH_LEN = 4'd3;
  localparam logic [STUCK_W-1:0]   DEF_STUCK_LIMIT = 16'd1000;

  typedef logic [ACK_W-1:0] ack_bus_t;

  // Add with clamp at all-ones; the counter must never wrap.
  function automatic logic [EDGE_CNT_W-1:0] edge_cnt_sat_add(
    input logic [EDGE_CNT_W-1:0] cnt,
    input logic [EDGE_CNT_W-1:0] inc
  );
    logic [EDGE_CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[EDGE_CNT_W] ? '1 : sum[EDGE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/scrod_ack_chan.sv
// One SCROD ACK channel: synchroniser, rising-edge detect, coincidence
// window stretcher, high-time counter and sticky stuck-high flag.
// Ports:
//   clk, rst       system clock, async active-high reset
//   ack_raw        raw asynchronous ACK line
//   stretch_len    extra window cycles (pulse lasts stretch_len+1 cycles)
//   stuck_limit    consecutive high cycles that flag the line; 0 disables
//   clr_stuck      clears the stuck flag and the high-time counter
//   ack            registered, stretched ACK
//   stuck          registered sticky stuck-high flag
//   accept_c       combinational: an edge is accepted this cycle
module scrod_ack_chan
  import caji_trg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = caji_trg_pkg::SYNC_STAGES,
  parameter int unsigned STRETCH_W   = caji_trg_pkg::STRETCH_W,
  parameter int unsigned STUCK_W     = caji_trg_pkg::STUCK_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ack_raw,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic [STUCK_W-1:0]   stuck_limit,
  input  logic                 clr_stuck,
  output logic                 ack,
  output logic                 stuck,
  output logic                 accept_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [STRETCH_W-1:0]   rem;
  logic [STUCK_W-1:0]     hi;
  logic [STUCK_W-1:0]     hi_inc;
  logic                   hit_limit;

  assign s        = sync[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  assign accept_c = rise & ~stuck;

  // Synchroniser chain plus edge-detect delay flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ack_raw};
      s_d  <= s;
    end
  end

  // Coincidence window; an accept inside an open window reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;
      rem <= '0;
    end else if (stuck) begin
      ack <= 1'b0;
      rem <= '0;
    end else if (accept_c) begin
      ack <= 1'b1;
      rem <= stretch_len;
    end else if (rem != '0) begin
      ack <= 1'b1;
      rem <= rem - STRETCH_W'(1);
    end else begin
      ack <= 1'b0;
    end
  end

  // hi_inc is the high-time including the cycle being sampled now, so the
  // flag sets on exactly the stuck_limit-th consecutive high sample.
  assign hi_inc    = (hi == '1) ? hi : hi + STUCK_W'(1);
  assign hit_limit = s && (stuck_limit != '0) && (hi_inc >= stuck_limit);

  // High-time counter and sticky flag; clear beats a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      stuck <= 1'b0;
    end else if (clr_stuck) begin
      hi    <= '0;
      stuck <= 1'b0;
    end else begin
      hi <= s ? hi_inc : '0;
      if (hit_limit) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scrod_ack_conditioner.sv
// Conditions the raw per-SCROD ACK lines for the trigger vote: one
// scrod_ack_chan per line plus a saturating count of accepted edges.
// Ports:
//   CLK_80MHZ    system clock
//   RESET        async active-high reset, clears every flop
//   ACK_RAW      raw asynchronous ACK lines
//   STRETCH_LEN  extra window cycles per accepted edge
//   STUCK_LIMIT  consecutive high cycles that flag a line stuck; 0 disables
//   CLR_STUCK    pulse: clear all stuck flags and high-time counters
//   CNT_CLR      pulse: zero EDGE_COUNT (drops same-cycle accepts)
//   ACK          conditioned ACK to TRIG
//   STUCK        sticky per-channel stuck-high flags
//   EDGE_COUNT   saturating count of accepted rising edges
module scrod_ack_conditioner
  import caji_trg_pkg::*;
#(
  parameter int unsigned NUM_SCRODS  = caji_trg_pkg::NUM_SCRODS,
  parameter int unsigned SYNC_STAGES = caji_trg_pkg::SYNC_STAGES,
  parameter int unsigned STRETCH_W   = caji_trg_pkg::STRETCH_W,
  parameter int unsigned STUCK_W     = caji_trg_pkg::STUCK_W
) (
  input  logic                  CLK_80MHZ,
  input  logic                  RESET,
  input  logic [NUM_SCRODS-1:0] ACK_RAW,
  input  logic [STRETCH_W-1:0]  STRETCH_LEN,
  input  logic [STUCK_W-1:0]    STUCK_LIMIT,
  input  logic                  CLR_STUCK,
  input  logic                  CNT_CLR,
  output logic [NUM_SCRODS-1:0] ACK,
  output logic [NUM_SCRODS-1:0] STUCK,
  output logic [EDGE_CNT_W-1:0] EDGE_COUNT
);

  localparam int unsigned POP_W = $clog2(NUM_SCRODS + 1);

  logic [NUM_SCRODS-1:0] accept;
  logic [POP_W-1:0]      accept_cnt;

  for (genvar i = 0; i < NUM_SCRODS; i++) begin : g_chan
    scrod_ack_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH_W   (STRETCH_W),
      .STUCK_W     (STUCK_W)
    ) u_chan (
      .clk         (CLK_80MHZ),
      .rst         (RESET),
      .ack_raw     (ACK_RAW[i]),
      .stretch_len (STRETCH_LEN),
      .stuck_limit (STUCK_LIMIT),
      .clr_stuck   (CLR_STUCK),
      .ack         (ACK[i]),
      .stuck       (STUCK[i]),
      .accept_c    (accept[i])
    );
  end

  // Popcount of simultaneous accepts; every channel's edge counts.
  always_comb begin
    accept_cnt = '0;
    for (int i = 0; i < NUM_SCRODS; i++) begin
      accept_cnt = accept_cnt + POP_W'(accept[i]);
    end
  end

  // Accepted-edge counter; clear takes priority over same-cycle accepts.
  always_ff @(posedge CLK_80MHZ or posedge RESET) begin
    if (RESET) begin
      EDGE_COUNT <= '0;
    end else if (CNT_CLR) begin
      EDGE_COUNT <= '0;
    end else begin
      EDGE_COUNT <= edge_cnt_sat_add(EDGE_COUNT, EDGE_CNT_W'(accept_cnt));
    end
  end

endmodule

// File: tb/tb_scrod_ack_conditioner.sv
// Directed bench for scrod_ack_conditioner. Inputs change and outputs are
// sampled just after each falling edge; the DUT acts on rising edges.
module tb_scrod_ack_conditioner;
  import caji_trg_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  ack_bus_t              ack_raw = '0;
  logic [STRETCH_W-1:0]  stretch_len = '0;
  logic [STUCK_W-1:0]    stuck_limit = '0;
  logic                  clr_stuck = 1'b0;
  logic                  cnt_clr = 1'b0;
  ack_bus_t              ack;
  ack_bus_t              stuck;
  logic [EDGE_CNT_W-1:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scrod_ack_conditioner dut (
    .CLK_80MHZ   (clk),
    .RESET       (rst),
    .ACK_RAW     (ack_raw),
    .STRETCH_LEN (stretch_len),
    .STUCK_LIMIT (stuck_limit),
    .CLR_STUCK   (clr_stuck),
    .CNT_CLR     (cnt_clr),
    .ACK         (ack),
    .STUCK       (stuck),
    .EDGE_COUNT  (edge_count)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_cnt_clr();
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] t2_exp [10];
    t2_exp = '{12'h000, 12'h000, 12'h00F, 12'h00F, 12'h01F,
               12'h01F, 12'h01F, 12'h010, 12'h010, 12'h000};

    // Reset state
    stretch_len = DEF_STRETCH_LEN;
    tick(3);
    chk_eq("rst_ack", 32'(ack), 32'h0);
    chk_eq("rst_stuck", 32'(stuck), 32'h0);
    chk_eq("rst_edge_count", edge_count, 32'h0);
    rst = 1'b0;
    tick(2);

    // 1: single one-cycle pulse, STRETCH_LEN=3 -> 4-cycle ACK after 3 edges
    stretch_len = 4'd3;
    ack_raw = 12'h001;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 1) ack_raw = '0;
      chk_eq($sformatf("t1_ack_k%0d", k), 32'(ack), (k >= 3 && k <= 6) ? 32'h001 : 32'h0);
    end
    chk_eq("t1_edge_count", edge_count, 32'd1);

    // 2: coincidence, held lines are not re-counted
    stretch_len = 4'd4;
    pulse_cnt_clr();
    chk_eq("t2_cnt_clr", edge_count, 32'd0);
    ack_raw = 12'h00F;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 2) ack_raw = 12'h01E;
      chk_eq($sformatf("t2_ack_k%0d", k), 32'(ack), 32'(t2_exp[k-1]));
    end
    chk_eq("t2_edge_count", edge_count, 32'd5);
    ack_raw = '0;
    tick(4);
    chk_eq("t2_ack_idle", 32'(ack), 32'h0);

    // 3: retrigger inside open window extends it without a gap
    stretch_len = 4'd5;
    pulse_cnt_clr();
    ack_raw = 12'h004;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      if (k == 1) ack_raw = '0;
      if (k == 3) ack_raw = 12'h004;
      if (k == 4) ack_raw = '0;
      chk_eq($sformatf("t3_ack_k%0d", k), 32'(ack), (k >= 3 && k <= 11) ? 32'h004 : 32'h0);
    end
    chk_eq("t3_edge_count", edge_count, 32'd2);

    // 4: stuck-high line 7, limit 10
    stretch_len = 4'd15;
    stuck_limit = 16'd10;
    pulse_cnt_clr();
    ack_raw = 12'h080;
    tick(11);
    chk_eq("t4_stuck_k11", 32'(stuck), 32'h0);
    chk_eq("t4_ack_k11", 32'(ack), 32'h080);
    tick(1);
    chk_eq("t4_stuck_k12", 32'(stuck), 32'h080);
    chk_eq("t4_ack_k12", 32'(ack), 32'h080);
    tick(1);
    chk_eq("t4_ack_forced_low", 32'(ack), 32'h0);
    chk_eq("t4_edge_count", edge_count, 32'd1);
    ack_raw = '0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk_eq($sformatf("t4_toggle_lo_k%0d", k), 32'(ack), 32'h0);
    end
    ack_raw = 12'h080;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk_eq($sformatf("t4_toggle_hi_k%0d", k), 32'(ack), 32'h0);
    end
    chk_eq("t4_edge_count_toggle", edge_count, 32'd1);
    chk_eq("t4_stuck_sticky", 32'(stuck), 32'h080);
    clr_stuck = 1'b1;
    tick(1);
    clr_stuck = 1'b0;
    chk_eq("t4_stuck_cleared", 32'(stuck), 32'h0);
    tick(9);
    chk_eq("t4_stuck_reflag_k9", 32'(stuck), 32'h0);
    tick(1);
    chk_eq("t4_stuck_reflag_k10", 32'(stuck), 32'h080);
    chk_eq("t4_ack_after_reflag", 32'(ack), 32'h0);
    chk_eq("t4_edge_count_final", edge_count, 32'd1);
    ack_raw = '0;
    stuck_limit = '0;
    tick(3);
    clr_stuck = 1'b1;
    tick(1);
    clr_stuck = 1'b0;

    // 5: saturation, then clear beats a same-cycle accept
    stretch_len = 4'd3;
    force dut.EDGE_COUNT = 32'hFFFF_FFFE;
    #1;
    release dut.EDGE_COUNT;
    ack_raw = 12'h003;
    tick(2);
    chk_eq("t5_preload", edge_count, 32'hFFFF_FFFE);
    tick(1);
    chk_eq("t5_saturate", edge_count, 32'hFFFF_FFFF);
    tick(2);
    chk_eq("t5_hold_sat", edge_count, 32'hFFFF_FFFF);
    ack_raw = 12'h007;
    tick(2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk_eq("t5_clr_with_edge", edge_count, 32'd0);
    chk_eq("t5_ack2_opened", 32'(ack[2]), 32'd1);
    tick(1);
    chk_eq("t5_clr_dropped", edge_count, 32'd0);

    // 6: async reset mid-window, then one edge for a still-high line
    stretch_len = 4'd7;
    ack_raw = '0;
    tick(4);
    ack_raw = 12'h100;
    tick(4);
    chk_eq("t6_ack_before", 32'(ack), 32'h100);
    chk_eq("t6_cnt_before", edge_count, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("t6_async_ack", 32'(ack), 32'h0);
    chk_eq("t6_async_stuck", 32'(stuck), 32'h0);
    chk_eq("t6_async_cnt", edge_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    chk_eq("t6_ack_k2", 32'(ack), 32'h0);
    tick(1);
    chk_eq("t6_ack_k3", 32'(ack), 32'h100);
    tick(12);
    chk_eq("t6_one_edge", edge_count, 32'd1);
    chk_eq("t6_ack_end", 32'(ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
